countdown_sequencer: RTL and testbench

- Controller for a cascaded BCD down-counter timer in MM:SS format (00:00–99:59).
- A TICK_DIV-cycle prescaler generates 1-unit ticks and sequences four chained BCD down-digits.
- Supports load, start, pause, resume and clear, and flags expiry with a state output and a one-cycle alarm pulse.
- Sits between debounced button pulses and the seven-segment display driver.

---
 rtl/countdown_sequencer_pkg.sv | 35 +++
 rtl/countdown_sequencer_bcd_down_digit.sv | 48 ++++
 rtl/countdown_sequencer.sv | 169 ++++++++++++++++
 tb/tb_countdown_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// countdown_sequencer_pkg
// Shared definitions for the MM:SS countdown timer:
//   - state_t     : controller state encoding (values visible on STATE)
//   - SEC_TENS_MAX: largest legal seconds-tens digit
//   - DEC_MAX     : largest legal decimal digit
//   - clamp_digit / clamp_preset : force an arbitrary preset into legal BCD
// ----------------------------------------------------------------------------
package countdown_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   localparam logic [3:0] SEC_TENS_MAX = 4'd5;
   localparam logic [3:0] DEC_MAX      = 4'd9;

   function automatic logic [3:0] clamp_digit(input logic [3:0] d,
                                              input logic [3:0] max_val);
      return (d > max_val) ? max_val : d;
   endfunction

   // Result layout matches TIME_OUT: {min tens, min units, sec tens, sec units}.
   function automatic logic [15:0] clamp_preset(input logic [7:0] pmin,
                                                input logic [7:0] psec);
      return {clamp_digit(pmin[7:4], DEC_MAX),
              clamp_digit(pmin[3:0], DEC_MAX),
              clamp_digit(psec[7:4], SEC_TENS_MAX),
              clamp_digit(psec[3:0], DEC_MAX)};
   endfunction

endpackage

// File: rtl/countdown_sequencer_bcd_down_digit.sv
// ----------------------------------------------------------------------------
// bcd_down_digit
// One BCD down-counting digit of a cascaded timer.
//   CLK      : system clock, rising edge
//   RESET_N  : asynchronous active-low reset (digit clears to 0)
//   LOAD     : load LOAD_VAL this cycle (has priority over DEC)
//   LOAD_VAL : value to load
//   DEC      : decrement request from the previous stage
//   VALUE    : current digit value
//   BORROW   : combinational, DEC while VALUE==0; feeds the next digit's DEC
// On a borrow the digit wraps to DIGIT_MAX.
// ----------------------------------------------------------------------------
module bcd_down_digit #(
   parameter logic [3:0] DIGIT_MAX = 4'd9
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       LOAD,
   input  logic [3:0] LOAD_VAL,
   input  logic       DEC,
   output logic [3:0] VALUE,
   output logic       BORROW
);

   logic [3:0] value_q;
   logic [3:0] value_d;

   always_comb begin
      value_d = value_q;
      if (LOAD) begin
         value_d = LOAD_VAL;
      end else if (DEC) begin
         value_d = (value_q == 4'd0) ? DIGIT_MAX : (value_q - 4'd1);
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         value_q <= 4'd0;
      end else begin
         value_q <= value_d;
      end
   end

   assign VALUE  = value_q;
   assign BORROW = DEC & (value_q == 4'd0);

endmodule

// File: rtl/countdown_sequencer.sv
// ----------------------------------------------------------------------------
// countdown_sequencer
// MM:SS countdown timer controller (00:00 .. 99:59) built from four chained
// BCD down-digits, a TICK_DIV-cycle prescaler and a four-state FSM.
//   CLK         : system clock, rising edge
//   RESET_N     : asynchronous active-low reset
//   START       : pulse, start from IDLE or resume from PAUSED
//   PAUSE       : pulse, pause while running
//   CLEAR       : pulse, abort to IDLE from any state
//   PRESET_MIN  : BCD minutes {tens, units}
//   PRESET_SEC  : BCD seconds {tens, units}
//   TIME_OUT    : current time {min tens, min units, sec tens, sec units}
//   STATE       : 0=IDLE 1=RUN 2=PAUSED 3=EXPIRED
//   RUNNING     : STATE==RUN
//   ALARM_PULSE : one-cycle pulse in the cycle after expiry
// Input priority is CLEAR > PAUSE > START.
// ----------------------------------------------------------------------------
module countdown_sequencer
   import countdown_sequencer_pkg::*;
#(
   parameter int TICK_DIV   = 100000000,
   parameter int TICK_WIDTH = 27
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        START,
   input  logic        PAUSE,
   input  logic        CLEAR,
   input  logic [7:0]  PRESET_MIN,
   input  logic [7:0]  PRESET_SEC,
   output logic [15:0] TIME_OUT,
   output logic [1:0]  STATE,
   output logic        RUNNING,
   output logic        ALARM_PULSE
);

   localparam logic [TICK_WIDTH-1:0] TICK_LAST = TICK_WIDTH'(TICK_DIV - 1);

   state_t                state_q, state_d;
   logic [TICK_WIDTH-1:0] presc_q, presc_d;
   logic                  alarm_q, alarm_d;

   logic [15:0] preset_clamped;
   logic        preset_zero;
   logic        load;
   logic        tick;
   logic        at_one;
   logic [3:0]  dec;
   logic        borrow_unused;

   assign preset_clamped = clamp_preset(PRESET_MIN, PRESET_SEC);
   assign preset_zero    = (preset_clamped == 16'h0000);
   assign at_one         = (TIME_OUT == 16'h0001);

   // Digits track the preset continuously while idle.
   assign load = (state_q == ST_IDLE);

   // CLEAR and PAUSE both suppress a coinciding tick.
   assign tick = (state_q == ST_RUN) && !CLEAR && !PAUSE && (presc_q == TICK_LAST);

   assign dec[0] = tick;

   bcd_down_digit #(.DIGIT_MAX(DEC_MAX)) u_sec_units (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .LOAD     (load),
      .LOAD_VAL (preset_clamped[3:0]),
      .DEC      (dec[0]),
      .VALUE    (TIME_OUT[3:0]),
      .BORROW   (dec[1])
   );

   bcd_down_digit #(.DIGIT_MAX(SEC_TENS_MAX)) u_sec_tens (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .LOAD     (load),
      .LOAD_VAL (preset_clamped[7:4]),
      .DEC      (dec[1]),
      .VALUE    (TIME_OUT[7:4]),
      .BORROW   (dec[2])
   );

   bcd_down_digit #(.DIGIT_MAX(DEC_MAX)) u_min_units (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .LOAD     (load),
      .LOAD_VAL (preset_clamped[11:8]),
      .DEC      (dec[2]),
      .VALUE    (TIME_OUT[11:8]),
      .BORROW   (dec[3])
   );

   // The top digit never borrows: RUN stops at 00:00 before decrementing it.
   bcd_down_digit #(.DIGIT_MAX(DEC_MAX)) u_min_tens (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .LOAD     (load),
      .LOAD_VAL (preset_clamped[15:12]),
      .DEC      (dec[3]),
      .VALUE    (TIME_OUT[15:12]),
      .BORROW   (borrow_unused)
   );

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      alarm_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            presc_d = '0;
            if (!CLEAR && START && !preset_zero) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (CLEAR) begin
               state_d = ST_IDLE;
               presc_d = '0;
            end else if (PAUSE) begin
               // Prescaler phase is frozen so resume continues the same second.
               state_d = ST_PAUSED;
            end else if (tick) begin
               presc_d = '0;
               if (at_one) begin
                  state_d = ST_EXPIRED;
                  alarm_d = 1'b1;
               end
            end else begin
               presc_d = presc_q + TICK_WIDTH'(1);
            end
         end
         ST_PAUSED: begin
            if (CLEAR) begin
               state_d = ST_IDLE;
               presc_d = '0;
            end else if (START) begin
               state_d = ST_RUN;
            end
         end
         ST_EXPIRED: begin
            if (CLEAR) begin
               state_d = ST_IDLE;
               presc_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            presc_d = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         presc_q <= '0;
         alarm_q <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         alarm_q <= alarm_d;
      end
   end

   assign STATE       = state_q;
   assign RUNNING     = (state_q == ST_RUN);
   assign ALARM_PULSE = alarm_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// ----------------------------------------------------------------------------
// tb_countdown_sequencer
// Directed scenarios followed by randomized pulses, with expected values from a
// reference model that tracks the remaining time as a plain count of seconds.
// ----------------------------------------------------------------------------
module tb_countdown_sequencer;

   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, pause, clear;
   logic [7:0]  pmin, psec;
   logic [15:0] time_out;
   logic [1:0]  state;
   logic        running;
   logic        alarm;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: 0=idle 1=run 2=paused 3=expired, remaining seconds,
   // cycles elapsed in the current second, pending alarm.
   int m_st;
   int m_rem;
   int m_ph;
   bit m_alarm;

   countdown_sequencer #(.TICK_DIV(TD), .TICK_WIDTH(3)) dut (
      .CLK         (clk),
      .RESET_N     (rst_n),
      .START       (start),
      .PAUSE       (pause),
      .CLEAR       (clear),
      .PRESET_MIN  (pmin),
      .PRESET_SEC  (psec),
      .TIME_OUT    (time_out),
      .STATE       (state),
      .RUNNING     (running),
      .ALARM_PULSE (alarm)
   );

   always #5 clk = ~clk;

   function automatic int clampn(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic int preset_secs(input logic [7:0] mn, input logic [7:0] sc);
      int m, s;
      m = clampn(int'(mn[7:4]), 9) * 10 + clampn(int'(mn[3:0]), 9);
      s = clampn(int'(sc[7:4]), 5) * 10 + clampn(int'(sc[3:0]), 9);
      return m * 60 + s;
   endfunction

   function automatic logic [15:0] to_bcd(input int secs);
      int m, s;
      m = secs / 60;
      s = secs % 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ":time"},    time_out,           to_bcd(m_rem));
      chk({tag, ":state"},   {14'd0, state},     16'(m_st));
      chk({tag, ":running"}, {15'd0, running},   16'(m_st == 1));
      chk({tag, ":alarm"},   {15'd0, alarm},     16'(m_alarm));
   endtask

   task automatic model_reset();
      m_st = 0; m_rem = 0; m_ph = 0; m_alarm = 0;
   endtask

   // Model of one clock edge given the inputs currently applied.
   task automatic model_edge(input logic s, input logic p, input logic c);
      int pre;
      pre = preset_secs(pmin, psec);
      m_alarm = 0;
      case (m_st)
         0: begin
            m_rem = pre;
            m_ph  = 0;
            if (!c && s && pre != 0) m_st = 1;
         end
         1: begin
            if (c) begin
               m_st = 0; m_ph = 0;
            end else if (p) begin
               m_st = 2;
            end else if (m_ph == TD - 1) begin
               m_ph  = 0;
               m_rem = m_rem - 1;
               if (m_rem == 0) begin
                  m_st = 3; m_alarm = 1;
               end
            end else begin
               m_ph++;
            end
         end
         2: begin
            if (c) begin
               m_st = 0; m_ph = 0;
            end else if (s) begin
               m_st = 1;
            end
         end
         default: begin
            if (c) begin
               m_st = 0; m_ph = 0;
            end
         end
      endcase
   endtask

   task automatic step(input string tag, input logic s, input logic p, input logic c);
      start = s; pause = p; clear = c;
      model_edge(s, p, c);
      @(posedge clk);
      #1;
      check_model(tag);
      start = 1'b0; pause = 1'b0; clear = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0; pause = 1'b0; clear = 1'b0;
      pmin  = 8'h00; psec = 8'h00;
      model_reset();
      #2;
      check_model("reset");
      chk("reset_time", time_out, 16'h0000);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      model_edge(0, 0, 0);
      check_model("post_reset");

      // 00:03 runs out after three ticks; alarm only in the following cycle.
      psec = 8'h03;
      step("t1_load", 0, 0, 0);
      step("t1_start", 1, 0, 0);
      for (int i = 1; i <= 12; i++) begin
         step("t1_run", 0, 0, 0);
         if (i == 4)  chk("t1_c4",  time_out, 16'h0002);
         if (i == 8)  chk("t1_c8",  time_out, 16'h0001);
         if (i == 11) chk("t1_noalarm_early", {15'd0, alarm}, 16'h0000);
      end
      chk("t1_c12_time",  time_out, 16'h0000);
      chk("t1_c12_state", {14'd0, state}, 16'h0003);
      chk("t1_c13_alarm", {15'd0, alarm}, 16'h0001);
      step("t1_after", 0, 0, 0);
      chk("t1_c14_alarm", {15'd0, alarm}, 16'h0000);
      step("t1_exp_start", 1, 1, 0);
      chk("t1_exp_hold", {14'd0, state}, 16'h0003);
      step("t1_clear", 0, 0, 1);

      // 10:00 borrows through every lower digit.
      pmin = 8'h10; psec = 8'h00;
      step("t2_load", 0, 0, 0);
      step("t2_start", 1, 0, 0);
      repeat (TD) step("t2_run", 0, 0, 0);
      chk("t2_borrow", time_out, 16'h0959);
      chk("t2_state", {14'd0, state}, 16'h0001);

      // Pause with two cycles of the second already elapsed.
      step("t3_run", 0, 0, 0);
      step("t3_run", 0, 0, 0);
      step("t3_pause", 0, 1, 0);
      pmin = 8'h42; psec = 8'h17;
      repeat (10) step("t3_hold", 0, 0, 0);
      chk("t3_hold_time",  time_out, 16'h0959);
      chk("t3_hold_state", {14'd0, state}, 16'h0002);
      step("t3_resume", 1, 0, 0);
      step("t3_r1", 0, 0, 0);
      chk("t3_r1_time", time_out, 16'h0959);
      step("t3_r2", 0, 0, 0);
      chk("t3_r2_time", time_out, 16'h0958);

      // Zero preset cannot start; out-of-range nibbles clamp.
      step("t4_clear", 0, 0, 1);
      pmin = 8'h00; psec = 8'h00;
      step("t4_load", 0, 0, 0);
      step("t4_start0", 1, 0, 0);
      chk("t4_zero_state", {14'd0, state}, 16'h0000);
      pmin = 8'hA3; psec = 8'h7F;
      step("t4_clamp", 0, 0, 0);
      chk("t4_clamp_time", time_out, 16'h9359);

      // CLEAR beats PAUSE and START arriving together.
      pmin = 8'h00; psec = 8'h05;
      step("t5_load", 0, 0, 0);
      step("t5_start", 1, 0, 0);
      step("t5_run", 0, 0, 0);
      step("t5_run", 0, 0, 0);
      pmin = 8'h01; psec = 8'h23;
      step("t5_all", 1, 1, 1);
      chk("t5_all_state", {14'd0, state}, 16'h0000);
      step("t5_reload", 0, 0, 0);
      chk("t5_reload_time", time_out, 16'h0123);
      chk("t5_reload_alarm", {15'd0, alarm}, 16'h0000);

      // Asynchronous reset in the middle of a run.
      step("t6_start", 1, 0, 0);
      repeat (5) step("t6_run", 0, 0, 0);
      #4 rst_n = 1'b0;
      model_reset();
      #1;
      check_model("t6_async");
      chk("t6_async_time", time_out, 16'h0000);
      #2 rst_n = 1'b1;
      pmin = 8'h00; psec = 8'h02;
      step("t6_load", 0, 0, 0);
      step("t6_start", 1, 0, 0);
      repeat (2 * TD) step("t6_run", 0, 0, 0);
      chk("t6_expired", {14'd0, state}, 16'h0003);
      step("t6_clear", 0, 0, 1);

      // Randomized pulses and presets.
      for (int i = 0; i < 3000; i++) begin
         logic s, p, c;
         s = ($urandom_range(0, 5) == 0);
         p = ($urandom_range(0, 11) == 0);
         c = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 15) == 0) begin
            pmin = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            psec = 8'($urandom);
         end
         step("rand", s, p, c);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
